drop_sequencer: RTL and testbench

//  - Control FSM that sequences the baggage-drop display/drop datapath.
//  - Arms on start, latches the time limit, and accepts measured fall-time samples from the height/sqrt path.
//  - Compares each sample against the limit and drives the registered t_act/t_lim/drop_en inputs of display_and_drop.
//  - Holds drop_en for a fixed window, then reports done; also provides abort and sample timeout.

---
 rtl/drop_sequencer.sv | 159 +++++++++++++++
 tb/tb_drop_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/drop_sequencer.sv
// Control FSM sequencing the baggage-drop display/drop datapath: arm, sample, compare, timed drop.
// Optional macro DROP_CONFIRM_EN requires CONFIRM_COUNT consecutive passing samples before dropping.
module drop_sequencer #(
   parameter int DATA_WIDTH     = 16,
   parameter int HOLD_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CONFIRM_COUNT  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] t_lim_in,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_t_act,
   output logic [DATA_WIDTH-1:0] t_act,
   output logic [DATA_WIDTH-1:0] t_lim,
   output logic                  drop_en,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 2 || CONFIRM_COUNT < 1) begin : g_bad_params
      $error("drop_sequencer: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SAMPLE,
      COMPARE,
      DROP
   } state_t;

   state_t                  state_q, state_d;
   logic [WAIT_W-1:0]       wait_q, wait_d;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic [DATA_WIDTH-1:0]   t_act_d, t_lim_d;
   logic                    drop_en_d, done_d, timeout_d;
   logic                    pass;

`ifdef DROP_CONFIRM_EN
   localparam int CONF_W = $clog2(CONFIRM_COUNT + 1);
   localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_COUNT - 1);
   logic [CONF_W-1:0]       conf_q, conf_d;
`endif

   assign pass = (t_act <= t_lim);
   assign busy = (state_q != IDLE);

   // Next-state and next-output logic; abort overrides everything and leaves data registers untouched.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      hold_d    = hold_q;
      t_act_d   = t_act;
      t_lim_d   = t_lim;
      drop_en_d = 1'b0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
`ifdef DROP_CONFIRM_EN
      conf_d    = conf_q;
`endif
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  t_lim_d = t_lim_in;
                  wait_d  = '0;
`ifdef DROP_CONFIRM_EN
                  conf_d  = '0;
`endif
                  state_d = WAIT_SAMPLE;
               end
            end
            WAIT_SAMPLE: begin
               if (sample_valid) begin
                  t_act_d = sample_t_act;
                  state_d = COMPARE;
               end else if (wait_q == WAIT_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            COMPARE: begin
               wait_d  = '0;
               state_d = WAIT_SAMPLE;
`ifdef DROP_CONFIRM_EN
               if (!pass) begin
                  conf_d = '0;
               end else begin
                  conf_d = conf_q + 1'b1;
                  if (conf_q >= CONF_LAST) begin
                     hold_d    = '0;
                     drop_en_d = 1'b1;
                     state_d   = DROP;
                  end
               end
`else
               if (pass) begin
                  hold_d    = '0;
                  drop_en_d = 1'b1;
                  state_d   = DROP;
               end
`endif
            end
            DROP: begin
               if (hold_q == HOLD_LAST) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  hold_d    = hold_q + 1'b1;
                  drop_en_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // All state and registered outputs share one asynchronously reset register bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wait_q  <= '0;
         hold_q  <= '0;
         t_act   <= '0;
         t_lim   <= '0;
         drop_en <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
`ifdef DROP_CONFIRM_EN
         conf_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         hold_q  <= hold_d;
         t_act   <= t_act_d;
         t_lim   <= t_lim_d;
         drop_en <= drop_en_d;
         done    <= done_d;
         timeout <= timeout_d;
`ifdef DROP_CONFIRM_EN
         conf_q  <= conf_d;
`endif
      end
   end

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed self-checking bench for drop_sequencer; expectation for the confirm test follows DROP_CONFIRM_EN.
module tb_drop_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] t_lim_in;
   logic        sample_valid;
   logic [15:0] sample_t_act;
   logic [15:0] t_act;
   logic [15:0] t_lim;
   logic        drop_en;
   logic        busy;
   logic        done;
   logic        timeout;

   int n_checks = 0;
   int n_fails  = 0;

   drop_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .t_lim_in     (t_lim_in),
      .sample_valid (sample_valid),
      .sample_t_act (sample_t_act),
      .t_act        (t_act),
      .t_lim        (t_lim),
      .drop_en      (drop_en),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic ab, input logic [15:0] lim,
                                input logic sv, input logic [15:0] smp);
      start        = st;
      abort        = ab;
      t_lim_in     = lim;
      sample_valid = sv;
      sample_t_act = smp;
      tick();
      start        = 1'b0;
      abort        = 1'b0;
      sample_valid = 1'b0;
   endtask

   // Counts consecutive drop_en cycles; leaves the bench on the first cycle with drop_en low.
   task automatic measureDrop(output int cycles);
      cycles = 0;
      while (drop_en === 1'b1 && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   int          cyc;
   int          n;
   int          hit_idx;
   int          exp_idx;
   logic        drop_seen;
   logic [15:0] vec [6];

   initial begin
      rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; t_lim_in = '0; sample_valid = 1'b0; sample_t_act = '0;
      repeat (3) tick();
      checkOutput("rst_t_act",   32'(t_act),   32'h0);
      checkOutput("rst_t_lim",   32'(t_lim),   32'h0);
      checkOutput("rst_drop_en", 32'(drop_en), 32'h0);
      checkOutput("rst_busy",    32'(busy),    32'h0);
      checkOutput("rst_done",    32'(done),    32'h0);
      checkOutput("rst_timeout", 32'(timeout), 32'h0);
      rst_n = 1'b1;
      tick();

      // Single passing sample.
      applyStimulus(1'b1, 1'b0, 16'h0250, 1'b0, 16'h0000);
      checkOutput("pass_busy",  32'(busy),  32'h1);
      checkOutput("pass_t_lim", 32'(t_lim), 32'h0250);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200);
      checkOutput("pass_t_act", 32'(t_act),   32'h0200);
      checkOutput("pass_nodrop_cmp", 32'(drop_en), 32'h0);
      tick();
      checkOutput("pass_drop_rise", 32'(drop_en), 32'h1);
      measureDrop(cyc);
      checkOutput("pass_hold_len", 32'(cyc),  32'd8);
      checkOutput("pass_done",     32'(done), 32'h1);
      tick();
      checkOutput("pass_done_end", 32'(done), 32'h0);
      checkOutput("pass_idle",     32'(busy), 32'h0);

      // Failing sample followed by an equal (passing) sample.
      applyStimulus(1'b1, 1'b0, 16'h0250, 1'b0, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0300);
      checkOutput("fail_t_act", 32'(t_act), 32'h0300);
      tick();
      checkOutput("fail_nodrop", 32'(drop_en), 32'h0);
      checkOutput("fail_busy",   32'(busy),    32'h1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0250);
      tick();
      checkOutput("eq_drop", 32'(drop_en), 32'h1);
      measureDrop(cyc);
      checkOutput("eq_hold_len", 32'(cyc),  32'd8);
      checkOutput("eq_done",     32'(done), 32'h1);
      tick();

      // Sample wait timeout.
      applyStimulus(1'b1, 1'b0, 16'h0250, 1'b0, 16'h0000);
      n = 0;
      drop_seen = 1'b0;
      while (timeout !== 1'b1 && n < 2000) begin
         tick();
         n++;
         if (drop_en === 1'b1) drop_seen = 1'b1;
      end
      checkOutput("to_cycles",  32'(n),         32'd1000);
      checkOutput("to_nodrop",  32'(drop_seen), 32'h0);
      checkOutput("to_idle",    32'(busy),      32'h0);
      checkOutput("to_no_done", 32'(done),      32'h0);
      tick();
      checkOutput("to_pulse_end", 32'(timeout), 32'h0);

      // sample_valid outside WAIT_SAMPLE is ignored.
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
      checkOutput("idle_sample_ign", 32'(t_act), 32'h0250);

      // Abort on the third drop_en cycle.
      applyStimulus(1'b1, 1'b0, 16'h0250, 1'b0, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100);
      tick();
      tick();
      tick();
      checkOutput("ab_drop_3rd", 32'(drop_en), 32'h1);
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
      checkOutput("ab_drop_off", 32'(drop_en), 32'h0);
      checkOutput("ab_idle",     32'(busy),    32'h0);
      checkOutput("ab_no_done",  32'(done),    32'h0);
      tick();
      checkOutput("ab_no_done2", 32'(done),    32'h0);
      checkOutput("ab_t_act",    32'(t_act),   32'h0100);
      checkOutput("ab_t_lim",    32'(t_lim),   32'h0250);

      // Start together with abort in IDLE stays idle.
      applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000);
      checkOutput("sa_idle",  32'(busy),  32'h0);
      checkOutput("sa_t_lim", 32'(t_lim), 32'h0250);

      // Confirm sequence: limit 0200, samples pass,pass,fail,pass,pass,pass.
      vec[0] = 16'h0100; vec[1] = 16'h0100; vec[2] = 16'h0300;
      vec[3] = 16'h0100; vec[4] = 16'h0100; vec[5] = 16'h0100;
`ifdef DROP_CONFIRM_EN
      exp_idx = 5;
`else
      exp_idx = 0;
`endif
      hit_idx = -1;
      applyStimulus(1'b1, 1'b0, 16'h0200, 1'b0, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         if (hit_idx < 0) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, vec[i]);
            tick();
            if (drop_en === 1'b1) hit_idx = i;
         end
      end
      checkOutput("cf_drop_idx", 32'(hit_idx), 32'(exp_idx));
      measureDrop(cyc);
      checkOutput("cf_hold_len", 32'(cyc),  32'd8);
      checkOutput("cf_done",     32'(done), 32'h1);
      tick();

      // Reset asserted in the middle of a drop window.
      applyStimulus(1'b1, 1'b0, 16'h0250, 1'b0, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0010);
      tick();
      tick();
      checkOutput("rd_drop_on", 32'(drop_en), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("rd_drop_async", 32'(drop_en), 32'h0);
      checkOutput("rd_busy",       32'(busy),    32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("rd_no_done", 32'(done), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
      $finish;
   end

endmodule
